spi_char_tx: RTL and testbench



---
 rtl/spi_char_tx.sv | 195 +++++++++++++++++++
 tb/tb_spi_char_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_char_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_char_tx
// Purpose  : SPI mode-0 master streaming queued character bytes, MSB first,
//            one framed transfer per byte.
// Revision : 1.0 - initial release
// ============================================================================
module spi_char_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          spi_sck,
    output logic                          spi_mosi,
    output logic                          spi_ss_n
);

    localparam int C_AW    = $clog2(FIFO_DEPTH);
    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [C_AW:0]      C_FULL     = (C_AW + 1)'(FIFO_DEPTH);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              r_state, w_state_n;
    logic [C_DIV_W-1:0]  r_div, w_div_n;
    logic [C_GAP_W-1:0]  r_gap, w_gap_n;
    logic [2:0]          r_bit, w_bit_n;
    logic [7:0]          r_shift, w_shift_n;
    logic                r_sck, w_sck_n;
    logic                r_ss_n, w_ss_n_n;
    logic                r_mosi, w_mosi_n;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [C_AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [C_AW:0]       r_count;
    logic                w_push, w_pop;

    // Ready depends on the registered count only, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign tx_ready   = (r_count != C_FULL);
    assign w_push     = tx_valid && tx_ready;
    assign fifo_count = r_count;
    assign busy       = (r_state != ST_IDLE) || (r_count != '0);
    assign spi_sck    = r_sck;
    assign spi_mosi   = r_mosi;
    assign spi_ss_n   = r_ss_n;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_gap   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sck   <= 1'b0;
            r_ss_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_gap   <= w_gap_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_sck   <= w_sck_n;
            r_ss_n  <= w_ss_n_n;
            r_mosi  <= w_mosi_n;
        end
    end

    // Next-state logic computes the pin values one cycle ahead so every SPI
    // output comes straight from a flop.
    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_gap_n   = r_gap;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_sck_n   = r_sck;
        w_ss_n_n  = r_ss_n;
        w_mosi_n  = r_mosi;
        w_pop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_shift_n = r_mem[r_rd_ptr];
                    w_mosi_n  = r_mem[r_rd_ptr][7];
                    w_ss_n_n  = 1'b0;
                    w_sck_n   = 1'b0;
                    w_div_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_div == C_DIV_LAST) begin
                    w_div_n   = '0;
                    w_sck_n   = 1'b1;
                    w_state_n = ST_HIGH;
                end else begin
                    w_div_n = r_div + 1'b1;
                end
            end
            ST_HIGH: begin
                if (r_div == C_DIV_LAST) begin
                    w_div_n   = '0;
                    w_sck_n   = 1'b0;
                    w_state_n = ST_LOW;
                    // Bit 0 stays on MOSI through the last LOW phase as SS hold.
                    if (r_bit != 3'd7) begin
                        w_shift_n = {r_shift[6:0], 1'b0};
                        w_mosi_n  = r_shift[6];
                    end
                end else begin
                    w_div_n = r_div + 1'b1;
                end
            end
            ST_LOW: begin
                if (r_div == C_DIV_LAST) begin
                    w_div_n = '0;
                    if (r_bit == 3'd7) begin
                        w_ss_n_n  = 1'b1;
                        w_mosi_n  = 1'b0;
                        w_gap_n   = '0;
                        w_state_n = ST_GAP;
                    end else begin
                        w_bit_n   = r_bit + 3'd1;
                        w_sck_n   = 1'b1;
                        w_state_n = ST_HIGH;
                    end
                end else begin
                    w_div_n = r_div + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap == C_GAP_LAST) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_gap_n = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_sck_n   = 1'b0;
                w_ss_n_n  = 1'b1;
                w_mosi_n  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_char_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_char_tx
// Purpose  : Directed self-checking bench for spi_char_tx (default and
//            CLK_DIV=1 / GAP_CYCLES=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_char_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data, tx_data1;
    logic       tx_valid, tx_valid1;
    logic       tx_ready, tx_ready1;
    logic [4:0] fifo_count, fifo_count1;
    logic       busy, busy1;
    logic       sck0, mosi0, ss0, sck1, mosi1, ss1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    spi_char_tx dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .fifo_count(fifo_count), .busy(busy),
        .spi_sck(sck0), .spi_mosi(mosi0), .spi_ss_n(ss0)
    );

    spi_char_tx #(.CLK_DIV(1), .FIFO_DEPTH(16), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .fifo_count(fifo_count1), .busy(busy1),
        .spi_sck(sck1), .spi_mosi(mosi1), .spi_ss_n(ss1)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // One record per completed SS-low window; times are posedge counts.
    typedef struct {
        logic [7:0] data;
        int rises, low, fall, firstabs, first, span, gap, endc;
    } frame_t;

    frame_t fr0[$];
    frame_t fr1[$];
    frame_t cur[2];
    logic   p_sck[2] = '{1'b0, 1'b0};
    logic   p_ss[2]  = '{1'b1, 1'b1};
    int     hi_cnt[2]   = '{0, 0};
    int     tot_rise[2] = '{0, 0};
    logic   m_sck[2], m_ss[2], m_mosi[2];

    assign m_sck[0] = sck0;  assign m_ss[0] = ss0;  assign m_mosi[0] = mosi0;
    assign m_sck[1] = sck1;  assign m_ss[1] = ss1;  assign m_mosi[1] = mosi1;

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (m_sck[k] && !p_sck[k]) tot_rise[k]++;
            if (!m_ss[k]) begin
                if (p_ss[k]) begin
                    cur[k].fall  = cyc;
                    cur[k].gap   = hi_cnt[k];
                    cur[k].rises = 0;
                    cur[k].low   = 0;
                    cur[k].data  = 8'h00;
                    cur[k].span  = 0;
                    cur[k].first = -1;
                end
                cur[k].low++;
                if (m_sck[k] && !p_sck[k]) begin
                    cur[k].data = {cur[k].data[6:0], m_mosi[k]};
                    if (cur[k].rises == 0) begin
                        cur[k].firstabs = cyc;
                        cur[k].first    = cyc - cur[k].fall;
                    end
                    cur[k].span = cyc - cur[k].firstabs;
                    cur[k].rises++;
                end
            end else begin
                if (!p_ss[k]) begin
                    cur[k].endc = cyc;
                    if (k == 0) fr0.push_back(cur[k]);
                    else        fr1.push_back(cur[k]);
                    hi_cnt[k] = 0;
                end
                hi_cnt[k]++;
            end
            p_sck[k] = m_sck[k];
            p_ss[k]  = m_ss[k];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 1'b0; tx_valid1 = 1'b0;
        tx_data = 8'h00; tx_data1 = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (sck0 !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b expected 0", sck0); end
        checks++; if (ss0 !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b expected 1", ss0); end
        checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int p, n;
        frame_t f;
        fr0.delete();
        @(negedge clk);
        tx_data = 8'h41; tx_valid = 1'b1; p = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        // First cycle after the push edge: queued, frame not yet open.
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        checks++; if (ss0 !== 1'b1) begin errors++; $display("FAIL single_ss_cycle1: got %b expected 1", ss0); end
        n = 0;
        while (fr0.size() < 1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (fr0.size() < 1) begin
            errors++; $display("FAIL single_timeout: got %0d frames expected 1", fr0.size());
        end else begin
            f = fr0[0];
            checks++; if (f.data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", f.data); end
            checks++; if (f.low != 68) begin errors++; $display("FAIL single_ss_low: got %0d expected 68", f.low); end
            checks++; if (f.rises != 8) begin errors++; $display("FAIL single_rises: got %0d expected 8", f.rises); end
            checks++; if (f.fall != p + 1) begin errors++; $display("FAIL single_ss_start: got %0d expected %0d", f.fall, p + 1); end
            checks++; if (f.first != 4) begin errors++; $display("FAIL single_first_rise: got %0d expected 4", f.first); end
            checks++; if (f.span != 56) begin errors++; $display("FAIL single_rise_span: got %0d expected 56", f.span); end
            n = 0;
            while (busy && n < 100) begin @(negedge clk); n++; end
            checks++; if (cyc - f.endc != 8) begin errors++; $display("FAIL single_busy_fall: got %0d expected 8", cyc - f.endc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] c1, c2;
        int n;
        fr0.delete();
        @(negedge clk); tx_data = 8'h48; tx_valid = 1'b1;
        @(negedge clk); c1 = fifo_count; tx_data = 8'h49;
        @(negedge clk); c2 = fifo_count; tx_valid = 1'b0;
        n = 0;
        while (fifo_count != 5'd0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (c1 !== 5'd1) begin errors++; $display("FAIL b2b_count1: got %0d expected 1", c1); end
        checks++; if (c2 !== 5'd1) begin errors++; $display("FAIL b2b_count2: got %0d expected 1", c2); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL b2b_count3: got %0d expected 0", fifo_count); end
        n = 0;
        while (fr0.size() < 2 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (fr0.size() < 2) begin
            errors++; $display("FAIL b2b_timeout: got %0d frames expected 2", fr0.size());
        end else begin
            checks++; if (fr0[0].data !== 8'h48) begin errors++; $display("FAIL b2b_data0: got %h expected 48", fr0[0].data); end
            checks++; if (fr0[1].data !== 8'h49) begin errors++; $display("FAIL b2b_data1: got %h expected 49", fr0[1].data); end
            checks++; if (fr0[1].fall - fr0[0].fall != 77) begin errors++; $display("FAIL b2b_period: got %0d expected 77", fr0[1].fall - fr0[0].fall); end
            // High time between frames covers the GAP phase plus the IDLE pop cycle.
            checks++; if (fr0[1].gap != 9) begin errors++; $display("FAIL b2b_ss_high: got %0d expected 9", fr0[1].gap); end
            checks++; if (fr0[1].low != 68) begin errors++; $display("FAIL b2b_ss_low: got %0d expected 68", fr0[1].low); end
        end
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic test_fill();
        int acc, n;
        logic r17;
        logic [4:0] c17;
        fr0.delete();
        acc = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            tx_data = 8'(i); tx_valid = 1'b1;
            if (tx_ready) acc++;
            if (i == 17) begin r17 = tx_ready; c17 = fifo_count; end
        end
        @(negedge clk); tx_valid = 1'b0;
        checks++; if (acc != 17) begin errors++; $display("FAIL fill_accepted: got %0d expected 17", acc); end
        checks++; if (r17 !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b expected 0", r17); end
        checks++; if (c17 !== 5'd16) begin errors++; $display("FAIL fill_count_full: got %0d expected 16", c17); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_count_held: got %0d expected 16", fifo_count); end
        n = 0;
        while (!tx_ready && n < 200) begin @(negedge clk); n++; end
        checks++; if (tx_ready !== 1'b1 || fifo_count !== 5'd15) begin errors++; $display("FAIL fill_ready_return: got ready=%b count=%0d expected ready=1 count=15", tx_ready, fifo_count); end
        n = 0;
        while (fr0.size() < 17 && n < 1700) begin @(negedge clk); n++; end
        repeat (150) @(negedge clk);
        checks++; if (fr0.size() != 17) begin errors++; $display("FAIL fill_frames: got %0d expected 17", fr0.size()); end
        for (int i = 0; i < 17 && i < fr0.size(); i++) begin
            checks++; if (fr0[i].data !== 8'(i)) begin errors++; $display("FAIL fill_data[%0d]: got %h expected %h", i, fr0[i].data, 8'(i)); end
        end
    endtask

    task automatic test_reset_midframe();
        int n, base;
        fr0.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); tx_data = 8'h61 + 8'(i); tx_valid = 1'b1;
        end
        @(negedge clk); tx_valid = 1'b0;
        n = 0;
        while (!(ss0 == 1'b0 && cur[0].rises == 5) && n < 300) begin @(negedge clk); n++; end
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL mid_count_before: got %0d expected 3", fifo_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (ss0 !== 1'b1) begin errors++; $display("FAIL mid_ss_n: got %b expected 1", ss0); end
        checks++; if (sck0 !== 1'b0) begin errors++; $display("FAIL mid_sck: got %b expected 0", sck0); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        base = tot_rise[0];
        repeat (120) @(negedge clk);
        checks++; if (tot_rise[0] != base) begin errors++; $display("FAIL mid_no_sck: got %0d rises expected 0", tot_rise[0] - base); end
        checks++; if (ss0 !== 1'b1) begin errors++; $display("FAIL mid_ss_idle: got %b expected 1", ss0); end
        fr0.delete();
    endtask

    task automatic test_div1();
        int p, n;
        fr1.delete();
        @(negedge clk); tx_data1 = 8'hA5; tx_valid1 = 1'b1; p = cyc + 1;
        @(negedge clk); tx_valid1 = 1'b0;
        n = 0;
        while (fr1.size() < 1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (fr1.size() < 1) begin
            errors++; $display("FAIL div1_timeout: got %0d frames expected 1", fr1.size());
        end else begin
            checks++; if (fr1[0].data !== 8'hA5) begin errors++; $display("FAIL div1_data: got %h expected a5", fr1[0].data); end
            checks++; if (fr1[0].low != 17) begin errors++; $display("FAIL div1_ss_low: got %0d expected 17", fr1[0].low); end
            checks++; if (fr1[0].rises != 8) begin errors++; $display("FAIL div1_rises: got %0d expected 8", fr1[0].rises); end
            checks++; if (fr1[0].first != 1) begin errors++; $display("FAIL div1_first_rise: got %0d expected 1", fr1[0].first); end
            checks++; if (fr1[0].span != 14) begin errors++; $display("FAIL div1_rise_span: got %0d expected 14", fr1[0].span); end
            checks++; if (fr1[0].fall != p + 1) begin errors++; $display("FAIL div1_ss_start: got %0d expected %0d", fr1[0].fall, p + 1); end
        end
    endtask

    task automatic test_stream();
        int sent, n, maxc;
        logic rdy;
        fr0.delete();
        sent = 0; n = 0; maxc = 0;
        @(negedge clk);
        tx_data = 8'h80; tx_valid = 1'b1;
        while (sent < 40 && n < 6000) begin
            rdy = tx_ready;
            @(negedge clk); n++;
            if (rdy) begin sent++; tx_data = tx_data + 8'd1; end
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        tx_valid = 1'b0;
        checks++; if (sent != 40) begin errors++; $display("FAIL stream_sent: got %0d expected 40", sent); end
        n = 0;
        while (fr0.size() < 40 && n < 4000) begin
            @(negedge clk); n++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        repeat (200) @(negedge clk);
        checks++; if (fr0.size() != 40) begin errors++; $display("FAIL stream_frames: got %0d expected 40", fr0.size()); end
        checks++; if (maxc != 16) begin errors++; $display("FAIL stream_max_count: got %0d expected 16", maxc); end
        for (int i = 0; i < 40 && i < fr0.size(); i++) begin
            checks++; if (fr0[i].data !== 8'h80 + 8'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, fr0[i].data, 8'h80 + 8'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_midframe();
        test_div1();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
